// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared widths and FSM state type for the cache controller
package cache_ctrl_pkg;
  localparam int CACHE_ADDR_W = 17;
  localparam int LINE_W       = 64;
  localparam int WORD_W       = 32;
  localparam int CNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_MISS = 2'd1,
    FILL      = 2'd2,
    WRITE     = 2'd3
  } state_t;
endpackage

// File: rtl/cache_stats_counter.sv
// rtl/cache_stats_counter.sv - saturating event counter for cache statistics
module cache_stats_counter
  import cache_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - write-through, no-allocate cache controller over a 64-bit SRAM line
// Optional hit/miss statistics built only when CACHE_STATS_EN is defined.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic [31:0]             address,
  input  logic [WORD_W-1:0]       wdata,
  output logic [WORD_W-1:0]       rdata,
  output logic                    ready,
  output logic [31:0]             sram_addr,
  output logic [WORD_W-1:0]       sram_wdata,
  output logic                    sram_r_en,
  output logic                    sram_w_en,
  input  logic [LINE_W-1:0]       sram_rdata,
  input  logic                    sram_ready,
  output logic [CACHE_ADDR_W-1:0] cache_address,
  output logic [LINE_W-1:0]       cache_write_data,
  output logic                    cache_read_en,
  output logic                    cache_write_en,
  output logic                    invalid,
  input  logic                    cache_hit,
  input  logic [WORD_W-1:0]       cache_read_data,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);

  state_t            state;
  logic [LINE_W-1:0] line_buf;
  logic [31:0]       offset;
  logic              line_req;

  assign offset           = address - BASE_ADDR;
  assign cache_address    = offset[18:2];
  assign cache_write_data = line_buf;
  assign sram_wdata       = wdata;
  assign sram_addr        = line_req ? {offset[31:3], 3'b000} : offset;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_w_en)                    state <= WRITE;
          else if (mem_r_en && !cache_hit) state <= READ_MISS;
        end
        READ_MISS: begin
          if (sram_ready) begin
            line_buf <= sram_rdata;
            state    <= FILL;
          end
        end
        FILL:    state <= IDLE;
        WRITE:   if (sram_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so hits complete in the request cycle; rst masks every strobe.
  always_comb begin
    ready          = 1'b1;
    rdata          = '0;
    sram_r_en      = 1'b0;
    sram_w_en      = 1'b0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    invalid        = 1'b0;
    line_req       = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (mem_w_en) begin
            invalid   = 1'b1;
            sram_w_en = 1'b1;
            ready     = 1'b0;
          end else if (mem_r_en) begin
            cache_read_en = 1'b1;
            if (cache_hit) begin
              rdata = cache_read_data;
            end else begin
              ready     = 1'b0;
              sram_r_en = 1'b1;
              line_req  = 1'b1;
            end
          end
        end
        READ_MISS: begin
          ready     = 1'b0;
          sram_r_en = 1'b1;
          line_req  = 1'b1;
        end
        FILL: begin
          cache_read_en  = 1'b1;
          cache_write_en = 1'b1;
          rdata          = address[2] ? line_buf[63:32] : line_buf[31:0];
        end
        WRITE: begin
          sram_w_en = 1'b1;
          ready     = sram_ready;
        end
        default: ready = 1'b1;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = (state == IDLE) && !mem_w_en && mem_r_en && cache_hit;
  assign miss_inc = (state == IDLE) && !mem_w_en && mem_r_en && !cache_hit;

  cache_stats_counter u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (hit_count)
  );

  cache_stats_counter u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (miss_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule
